lcd_st7789_rx: RTL and testbench

- Responder-side model of the ST7789V3 4-wire serial interface: receives the SCL/SD/CS/RS/RST pins driven by the LCD driver.
- Oversamples the pins on the system clock, deserialises bytes and decodes the command stream. Tracks CASET/RASET window state and emits addressed RGB565 pixels during RAMWR.
- Used as the on-chip or bench loopback checker for the LCD driver, and as a building block for a frame-capture monitor.

---
 rtl/lcd_st7789_rx.sv | 276 +++++++++++++++++++++++++++
 tb/tb_lcd_st7789_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_st7789_rx.sv
// lcd_st7789_rx: receives the ST7789V3 4-wire serial bus (SCL/SD/CS/RS plus
// the panel reset pin), oversampled on the system clock.
//
// The block deserialises bytes and decodes the command stream. It tracks the
// CASET/RASET address window and emits addressed RGB565 pixels during RAMWR.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   lcd_rst            panel reset pin (active-low), clears all state
//   lcd_cs/scl/sd/rs   serial bus pins (CS active-low, SD sampled on SCL rise)
//   rx_valid/rx_byte/rx_is_cmd   one-cycle strobe per received byte
//   frame_err          one-cycle strobe when CS rises mid-byte
//   cmd_valid/cmd_code one-cycle strobe per command byte, last command held
//   pix_valid/pix_x/pix_y/pix_data  one-cycle strobe per completed pixel
module lcd_st7789_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DEF_XE      = 16'd239,
  parameter logic [15:0] DEF_YE      = 16'd319
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_rst,
  input  logic        lcd_cs,
  input  logic        lcd_scl,
  input  logic        lcd_sd,
  input  logic        lcd_rs,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        rx_is_cmd,
  output logic        frame_err,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data
);

  typedef enum logic [1:0] {CMD_NONE, CMD_CASET, CMD_RASET, CMD_RAMWR} cmd_state_e;

  // Pin vector order: {lcd_rst, lcd_cs, lcd_scl, lcd_sd, lcd_rs}
  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  // Edge history is only consumed for SCL (bit 1) and CS (bit 0)
  logic [1:0]  hist_q, hist_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rx_valid_q, rx_valid_d, rx_is_cmd_q, rx_is_cmd_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        frame_err_q, frame_err_d;
  cmd_state_e  state_q, state_d;
  logic [2:0]  arg_cnt_q, arg_cnt_d;
  logic [7:0]  sh_q, sh_d, sl_q, sl_d, eh_q, eh_d;
  logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic        half_q, half_d;
  logic        cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_data_q, pix_data_d;

  logic [4:0] pins_s;
  logic       rst_n_s, cs_s, scl_s, sd_s, rs_s, scl_rise, cs_rise;

  assign pins_s   = sync_q[SYNC_STAGES-1];
  assign rst_n_s  = pins_s[4];
  assign cs_s     = pins_s[3];
  assign scl_s    = pins_s[2];
  assign sd_s     = pins_s[1];
  assign rs_s     = pins_s[0];
  assign scl_rise = scl_s & ~hist_q[1];
  assign cs_rise  = cs_s & ~hist_q[0];

  // Synchroniser chain and edge history; never cleared by the panel reset pin
  always_comb begin
    sync_d[0] = {lcd_rst, lcd_cs, lcd_scl, lcd_sd, lcd_rs};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    hist_d = {scl_s, cs_s};
  end

  // Deserialiser
  // NOTE: every signal gets its default first, so no path can infer a latch.
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    rx_is_cmd_d = rx_is_cmd_q;
    frame_err_d = 1'b0;
    if (!rst_n_s) begin
      shift_d     = '0;
      cnt_d       = '0;
      rx_byte_d   = '0;
      rx_is_cmd_d = 1'b0;
    end else if (scl_rise && !cs_s) begin
      shift_d = {shift_q[6:0], sd_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        rx_valid_d  = 1'b1;
        rx_byte_d   = {shift_q[6:0], sd_s};
        rx_is_cmd_d = ~rs_s;
      end
    end else if (cs_rise && cnt_q != 3'd0) begin
      cnt_d       = '0;
      frame_err_d = 1'b1;
    end
  end

  // Command parser, one cycle behind the byte strobe
  always_comb begin
    state_d     = state_q;
    arg_cnt_d   = arg_cnt_q;
    sh_d        = sh_q;
    sl_d        = sl_q;
    eh_d        = eh_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    half_d      = half_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_data_d  = pix_data_q;
    if (!rst_n_s) begin
      state_d    = CMD_NONE;
      arg_cnt_d  = '0;
      sh_d       = '0;
      sl_d       = '0;
      eh_d       = '0;
      xs_d       = '0;
      xe_d       = DEF_XE;
      ys_d       = '0;
      ye_d       = DEF_YE;
      cur_x_d    = '0;
      cur_y_d    = '0;
      half_d     = 1'b0;
      cmd_code_d = '0;
      pix_x_d    = '0;
      pix_y_d    = '0;
      pix_data_d = '0;
    end else if (rx_valid_q) begin
      if (rx_is_cmd_q) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = rx_byte_q;
        arg_cnt_d   = '0;
        half_d      = 1'b0;
        case (rx_byte_q)
          8'h2A:   state_d = CMD_CASET;
          8'h2B:   state_d = CMD_RASET;
          8'h2C: begin
            state_d = CMD_RAMWR;
            cur_x_d = xs_q;
            cur_y_d = ys_q;
          end
          default: state_d = CMD_NONE;
        endcase
      end else begin
        case (state_q)
          CMD_CASET, CMD_RASET: begin
            // Window commits only on the 4th argument; later bytes are ignored
            if (arg_cnt_q != 3'd4) arg_cnt_d = arg_cnt_q + 3'd1;
            case (arg_cnt_q)
              3'd0: sh_d = rx_byte_q;
              3'd1: sl_d = rx_byte_q;
              3'd2: eh_d = rx_byte_q;
              3'd3: begin
                if (state_q == CMD_CASET) begin
                  xs_d = {sh_q, sl_q};
                  xe_d = {eh_q, rx_byte_q};
                end else begin
                  ys_d = {sh_q, sl_q};
                  ye_d = {eh_q, rx_byte_q};
                end
              end
              default: ;
            endcase
          end
          CMD_RAMWR: begin
            if (!half_q) begin
              pix_data_d[15:8] = rx_byte_q;
              half_d           = 1'b1;
            end else begin
              pix_data_d[7:0] = rx_byte_q;
              pix_valid_d     = 1'b1;
              pix_x_d         = cur_x_q;
              pix_y_d         = cur_y_q;
              half_d          = 1'b0;
              if (cur_x_q == xe_q) begin
                cur_x_d = xs_q;
                cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 16'd1;
              end else begin
                cur_x_d = cur_x_q + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '1;
      hist_q      <= '1;
      shift_q     <= '0;
      cnt_q       <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      rx_is_cmd_q <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= CMD_NONE;
      arg_cnt_q   <= '0;
      sh_q        <= '0;
      sl_q        <= '0;
      eh_q        <= '0;
      xs_q        <= '0;
      xe_q        <= DEF_XE;
      ys_q        <= '0;
      ye_q        <= DEF_YE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      half_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_data_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rx_valid_q  <= rx_valid_d;
      rx_byte_q   <= rx_byte_d;
      rx_is_cmd_q <= rx_is_cmd_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      arg_cnt_q   <= arg_cnt_d;
      sh_q        <= sh_d;
      sl_q        <= sl_d;
      eh_q        <= eh_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      half_q      <= half_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_byte   = rx_byte_q;
  assign rx_is_cmd = rx_is_cmd_q;
  assign frame_err = frame_err_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_lcd_st7789_rx.sv
// Bench for lcd_st7789_rx: drives the serial pins like an LCD driver and checks
// every strobe against a queue-based model of the bus protocol. Pixel
// positions are derived from a pixel index within the window.
module tb_lcd_st7789_rx;
  localparam int SS = 2;

  logic clk = 1'b0, rst = 1'b1, lcd_rst = 1'b1, lcd_cs = 1'b1;
  logic lcd_scl = 1'b1, lcd_sd = 1'b1, lcd_rs = 1'b1;
  logic rx_valid, rx_is_cmd, frame_err, cmd_valid, pix_valid;
  logic [7:0] rx_byte, cmd_code;
  logic [15:0] pix_x, pix_y, pix_data;

  lcd_st7789_rx #(.SYNC_STAGES(SS), .DEF_XE(16'd239), .DEF_YE(16'd319)) dut (
    .clk(clk), .rst(rst), .lcd_rst(lcd_rst), .lcd_cs(lcd_cs), .lcd_scl(lcd_scl),
    .lcd_sd(lcd_sd), .lcd_rs(lcd_rs), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_is_cmd(rx_is_cmd), .frame_err(frame_err), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected events ({is_cmd, byte}, code, {x, y, data}) and observed logs
  logic [8:0]  exp_rx[$];
  logic [7:0]  exp_cmd[$];
  logic [47:0] exp_pix[$];
  int          exp_ferr = 0;
  logic [8:0]  log_rx[$];
  logic [7:0]  log_cmd[$];
  logic [47:0] log_pix[$];
  int          log_ferr = 0;

  // Protocol model: mode 0 none, 1 column window, 2 row window, 3 memory write
  int         m_mode, m_argc, m_n, xs, xe, ys, ye;
  logic [7:0] m_args[4];
  bit         m_half;
  logic [7:0] m_hi;

  task automatic model_reset();
    m_mode = 0; m_argc = 0; m_n = 0; m_half = 0;
    xs = 0; xe = 239; ys = 0; ye = 319;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit is_cmd);
    int px, py;
    exp_rx.push_back({is_cmd, b});
    if (is_cmd) begin
      exp_cmd.push_back(b);
      m_argc = 0; m_half = 0; m_n = 0;
      m_mode = (b == 8'h2A) ? 1 : (b == 8'h2B) ? 2 : (b == 8'h2C) ? 3 : 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_argc < 4) begin
        m_args[m_argc] = b;
        m_argc++;
        if (m_argc == 4) begin
          if (m_mode == 1) begin
            xs = {m_args[0], m_args[1]}; xe = {m_args[2], m_args[3]};
          end else begin
            ys = {m_args[0], m_args[1]}; ye = {m_args[2], m_args[3]};
          end
        end
      end
    end else if (m_mode == 3) begin
      if (!m_half) begin
        m_hi = b; m_half = 1;
      end else begin
        px = xs + m_n % (xe - xs + 1);
        py = ys + (m_n / (xe - xs + 1)) % (ye - ys + 1);
        exp_pix.push_back({px[15:0], py[15:0], m_hi, b});
        m_n++; m_half = 0;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full byte, MSB first, 4-cycle SCL phases; also measures strobe latency
  task automatic send_byte(input logic [7:0] b, input bit is_cmd);
    int lat;
    model_byte(b, is_cmd);
    for (int i = 7; i >= 0; i--) begin
      lcd_scl = 1'b0; lcd_sd = b[i]; lcd_rs = ~is_cmd;
      tick(4);
      lcd_scl = 1'b1;
      if (i != 0) tick(4);
    end
    lat = -1;
    for (int c = 0; c <= SS + 3; c++) begin
      @(negedge clk);
      if (rx_valid && lat < 0) lat = c;
    end
    @(posedge clk); #1;
    check("rx_latency", lat, SS + 1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      lcd_scl = 1'b0; lcd_sd = b[i]; lcd_rs = 1'b1;
      tick(4);
      lcd_scl = 1'b1;
      tick(4);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_byte"}, rx_byte, 0);
    check({tag, "_cmd_code"}, cmd_code, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_strobes"}, {rx_valid, rx_is_cmd, frame_err, cmd_valid, pix_valid}, 0);
  endtask

  // Compare process: every strobe is matched against the model queues
  logic rx_prev = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin
      log_rx.push_back({rx_is_cmd, rx_byte});
      check("rx_expected", exp_rx.size() != 0, 1);
      if (exp_rx.size() != 0) check("rx_byte_cmd", {rx_is_cmd, rx_byte}, exp_rx.pop_front());
      check("rx_no_ferr_same_cycle", frame_err, 0);
    end
    if (cmd_valid) begin
      log_cmd.push_back(cmd_code);
      check("cmd_after_rx", rx_prev, 1);
      check("cmd_expected", exp_cmd.size() != 0, 1);
      if (exp_cmd.size() != 0) check("cmd_code", cmd_code, exp_cmd.pop_front());
    end
    if (pix_valid) begin
      log_pix.push_back({pix_x, pix_y, pix_data});
      check("pix_after_rx", rx_prev, 1);
      check("pix_expected", exp_pix.size() != 0, 1);
      if (exp_pix.size() != 0) check("pix_xy_data", {pix_x, pix_y, pix_data}, exp_pix.pop_front());
    end
    if (frame_err) begin
      log_ferr++;
      check("ferr_expected", exp_ferr > 0, 1);
      if (exp_ferr > 0) exp_ferr--;
    end
    rx_prev = rx_valid;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r, nd;
    logic [7:0] c, s, e;
    model_reset();

    // Reset and idle pins
    tick(3);
    rst = 1'b0;
    tick(100);
    check_outputs_zero("idle");
    check("idle_no_rx", log_rx.size(), 0);

    // Single command byte 0x11
    lcd_cs = 1'b0;
    tick(4);
    send_byte(8'h11, 1);
    tick(4);
    check("cmd11_rx_count", log_rx.size(), 1);
    check("cmd11_rx", log_rx[0], 9'h111);
    check("cmd11_cmd", log_cmd[0], 8'h11);

    // 135-wide window, 136 pixels wraps to (0,1)
    log_pix.delete();
    send_byte(8'h2A, 1); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h86, 0);
    send_byte(8'h2B, 1); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'hEF, 0);
    send_byte(8'h2C, 1);
    for (int k = 0; k < 136; k++) begin
      send_byte(8'h00, 0);
      send_byte(k[7:0], 0);
    end
    tick(6);
    check("wide_pix_count", log_pix.size(), 136);
    check("wide_pix0", log_pix[0], {16'd0, 16'd0, 16'h0000});
    check("wide_pix134", log_pix[134], {16'd134, 16'd0, 16'h0086});
    check("wide_pix135", log_pix[135], {16'd0, 16'd1, 16'h0087});

    // 2x2 window at (5,10)
    log_pix.delete();
    send_byte(8'h2A, 1); send_byte(8'h00, 0); send_byte(8'h05, 0);
    send_byte(8'h00, 0); send_byte(8'h06, 0);
    send_byte(8'h2B, 1); send_byte(8'h00, 0); send_byte(8'h0A, 0);
    send_byte(8'h00, 0); send_byte(8'h0B, 0);
    send_byte(8'h2C, 1);
    for (int k = 0; k < 5; k++) begin
      send_byte(8'hF0 + k[7:0], 0);
      send_byte(8'h0F, 0);
    end
    tick(6);
    check("win_pix_count", log_pix.size(), 5);
    check("win_pix0_xy", log_pix[0][47:16], {16'd5, 16'd10});
    check("win_pix1_xy", log_pix[1][47:16], {16'd6, 16'd10});
    check("win_pix2_xy", log_pix[2][47:16], {16'd5, 16'd11});
    check("win_pix3_xy", log_pix[3][47:16], {16'd6, 16'd11});
    check("win_pix4_xy", log_pix[4][47:16], {16'd5, 16'd10});
    check("win_pix4_data", log_pix[4][15:0], 16'hF40F);

    // CS rises after 5 bits
    base = log_rx.size();
    send_bits(8'hFF, 5);
    exp_ferr++;
    lcd_cs = 1'b1;
    tick(10);
    lcd_cs = 1'b0;
    tick(4);
    check("abort_ferr_count", log_ferr, 1);
    check("abort_no_rx", log_rx.size(), base);
    send_byte(8'hA5, 0);
    tick(2);
    check("after_abort_rx", log_rx[log_rx.size() - 1], 9'h0A5);

    // rst mid-byte
    send_bits(8'h3C, 3);
    rst = 1'b1;
    #2;
    check_outputs_zero("rst");
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(6);
    log_pix.delete();
    send_byte(8'h2C, 1);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h56, 0); send_byte(8'h78, 0);
    tick(4);
    check("rst_pix0", log_pix[0], {16'd0, 16'd0, 16'h1234});
    check("rst_pix1", log_pix[1], {16'd1, 16'd0, 16'h5678});

    // lcd_rst mid-byte after moving the window
    send_byte(8'h2A, 1); send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h00, 0); send_byte(8'h09, 0);
    send_byte(8'h2B, 1); send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_bits(8'h81, 4);
    lcd_rst = 1'b0;
    tick(SS + 3);
    check_outputs_zero("lcdrst");
    lcd_rst = 1'b1;
    model_reset();
    tick(SS + 4);
    log_pix.delete();
    send_byte(8'h2C, 1);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    send_byte(8'hEF, 0); send_byte(8'h01, 0);
    tick(4);
    check("lcdrst_pix0", log_pix[0], {16'd0, 16'd0, 16'hABCD});
    check("lcdrst_pix1", log_pix[1], {16'd1, 16'd0, 16'hEF01});

    // Randomised command stream with occasional aborted bytes
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 3);
      c = (r == 0) ? 8'h2A : (r == 1) ? 8'h2B : (r == 2) ? 8'h2C : 8'($urandom_range(0, 255));
      if (r == 3 && c >= 8'h2A && c <= 8'h2C) c = c + 8'h10;
      send_byte(c, 1);
      nd = $urandom_range(0, 7);
      s = 8'($urandom_range(0, 20));
      e = s + 8'($urandom_range(0, 4));
      for (int d = 0; d < nd; d++) begin
        if ((r == 0 || r == 1) && d < 4)
          send_byte((d == 1) ? s : (d == 3) ? e : 8'h00, 0);
        else
          send_byte(8'($urandom_range(0, 255)), 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        send_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7));
        exp_ferr++;
        lcd_cs = 1'b1;
        tick(8);
        lcd_cs = 1'b0;
        tick(4);
      end
    end

    tick(10);
    check("drain_rx", exp_rx.size(), 0);
    check("drain_cmd", exp_cmd.size(), 0);
    check("drain_pix", exp_pix.size(), 0);
    check("drain_ferr", exp_ferr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
